// File: rtl/bounce_gen_if.sv
// Command handshake between a level-command source and the bounce emulator.
interface bounce_gen_if;
    logic cmd_valid;
    logic cmd_level;
    logic cmd_ready;

    modport master (output cmd_valid, output cmd_level, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_level, output cmd_ready);
endinterface

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: takes clean level commands and drives a noisy output
// that chatters from an LFSR for a bounce window, then holds the new level.
//
// state  | meaning
// IDLE   | output steady, ready for a command
// BOUNCE | output chattering toward the target level
// SETTLE | output held at target until the hold time expires
module bounce_gen #(
    parameter int          BOUNCE_CYC = 64,
    parameter int          HOLD_CYC   = 32,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    bounce_gen_if.slave  cmd,
    output logic         noisy_out,
    output logic         busy,
    output logic         settled
);

    localparam int MAX_CYC = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] BOUNCE_LOAD = CW'(BOUNCE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYC - 1);
    localparam logic [15:0]   LFSR_MASK   = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] counter, counter_n;
    logic [15:0]   lfsr, lfsr_n;
    logic          target, target_n;
    logic          noisy_n;
    logic          settled_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            counter   <= '0;
            lfsr      <= SEED;
            target    <= INIT_LEVEL;
            noisy_out <= INIT_LEVEL;
            settled   <= 1'b0;
        end else begin
            state     <= state_n;
            counter   <= counter_n;
            lfsr      <= lfsr_n;
            target    <= target_n;
            noisy_out <= noisy_n;
            settled   <= settled_n;
        end
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        lfsr_n    = lfsr;
        target_n  = target;
        noisy_n   = noisy_out;
        settled_n = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    // A command for the level already present completes at once.
                    if (cmd.cmd_level == noisy_out) begin
                        settled_n = 1'b1;
                    end else begin
                        state_n   = BOUNCE;
                        target_n  = cmd.cmd_level;
                        noisy_n   = cmd.cmd_level;
                        counter_n = BOUNCE_LOAD;
                    end
                end
            end
            BOUNCE: begin
                if (counter != '0) begin
                    noisy_n   = noisy_out ^ lfsr[0];
                    counter_n = counter - 1'b1;
                    lfsr_n    = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
                end else begin
                    state_n   = SETTLE;
                    noisy_n   = target;
                    counter_n = HOLD_LOAD;
                end
            end
            SETTLE: begin
                noisy_n = target;
                if (counter != '0) begin
                    counter_n = counter - 1'b1;
                end else begin
                    state_n   = IDLE;
                    settled_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen (BOUNCE_CYC=8, HOLD_CYC=4) with hand-derived
// bounce patterns from SEED 16'hACE1 and a small debouncer loopback model.
module tb_bounce_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic noisy_out;
    logic busy;
    logic settled;

    bounce_gen_if cmd_if ();

    bounce_gen #(
        .BOUNCE_CYC (8),
        .HOLD_CYC   (4),
        .SEED       (16'hACE1),
        .INIT_LEVEL (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .noisy_out (noisy_out),
        .busy      (busy),
        .settled   (settled)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Debouncer model: output follows the input after 6 stable differing cycles.
    logic db_out = 1'b1;
    int   db_cnt = 0;
    int   db_toggles = 0;
    always @(negedge clk) begin
        if (noisy_out != db_out) begin
            db_cnt = db_cnt + 1;
            if (db_cnt >= 6) begin
                db_out     = noisy_out;
                db_cnt     = 0;
                db_toggles = db_toggles + 1;
            end
        end else begin
            db_cnt = 0;
        end
    end

    // Caller has cmd_valid/cmd_level set; the next edge is the accept edge E0.
    // pat[k] is the expected noisy_out after edge Ek for k = 0..7.
    task automatic run_trans(input logic lvl, input logic [7:0] pat,
                             input bit poke, input bit hold_next, input logic next_lvl);
        step();
        cmd_if.cmd_valid = 1'b0;
        chk("e0_noisy", int'(noisy_out), int'(pat[0]));
        chk("e0_ready", int'(cmd_if.cmd_ready), 0);
        chk("e0_settled", int'(settled), 0);
        for (int k = 1; k <= 11; k++) begin
            if (poke && k == 3) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_level = ~lvl;
            end
            if (poke && k == 4) cmd_if.cmd_valid = 1'b0;
            if (hold_next && k == 10) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_level = next_lvl;
            end
            step();
            if (k <= 7) chk($sformatf("bounce_e%0d", k), int'(noisy_out), int'(pat[k]));
            else        chk($sformatf("hold_e%0d", k), int'(noisy_out), int'(lvl));
            chk($sformatf("busy_e%0d", k), int'(busy), 1);
            chk($sformatf("nosettle_e%0d", k), int'(settled), 0);
        end
        step();
        chk("e12_settled", int'(settled), 1);
        chk("e12_ready", int'(cmd_if.cmd_ready), 1);
        chk("e12_noisy", int'(noisy_out), int'(lvl));
        if (!hold_next) begin
            step();
            chk("e13_settled_clear", int'(settled), 0);
        end
    endtask

    initial begin
        int base;
        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_level = 1'b0;
        repeat (3) step();
        chk("rst_noisy", int'(noisy_out), 0);
        chk("rst_ready", int'(cmd_if.cmd_ready), 1);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_noisy", int'(noisy_out), 0);
            chk("idle_settled", int'(settled), 0);
            chk("idle_ready", int'(cmd_if.cmd_ready), 1);
            chk("idle_busy", int'(busy), 0);
        end

        // Rising from SEED: lfsr[0] = 1,0,0,0,0,1,1 over E1..E7.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_level = 1'b1;
        run_trans(1'b1, 8'b0100_0001, 1'b0, 1'b0, 1'b0);

        // Same level: completes next cycle without going busy.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_level = 1'b1;
        step();
        cmd_if.cmd_valid = 1'b0;
        chk("same_settled", int'(settled), 1);
        chk("same_busy", int'(busy), 0);
        chk("same_noisy", int'(noisy_out), 1);
        step();
        chk("same_settled_clear", int'(settled), 0);
        chk("same_busy2", int'(busy), 0);

        // Falling from lfsr 16'hED89 (unchanged by the same-level command),
        // with an ignored poke during BOUNCE and a back-to-back rising command.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_level = 1'b0;
        run_trans(1'b0, 8'b0000_1110, 1'b1, 1'b1, 1'b1);
        run_trans(1'b1, 8'b0000_1101, 1'b0, 1'b0, 1'b0);

        // Reset while in SETTLE.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_level = 1'b0;
        step();
        cmd_if.cmd_valid = 1'b0;
        repeat (9) step();
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_noisy", int'(noisy_out), 0);
        chk("midrst_ready", int'(cmd_if.cmd_ready), 1);
        chk("midrst_settled", int'(settled), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) begin
            step();
            chk("postrst_settled", int'(settled), 0);
            chk("postrst_noisy", int'(noisy_out), 0);
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_level = 1'b1;
        run_trans(1'b1, 8'b0100_0001, 1'b0, 1'b0, 1'b0);

        // Loopback through the debouncer model.
        repeat (10) step();
        chk("lb_start", int'(db_out), 1);
        for (int c = 0; c < 10; c++) begin
            logic lvl;
            bit   seen;
            lvl  = (c % 2 == 0) ? 1'b0 : 1'b1;
            base = db_toggles;
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_level = lvl;
            step();
            cmd_if.cmd_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                step();
                seen = settled;
            end
            chk($sformatf("lb_settled_%0d", c), int'(seen), 1);
            repeat (10) step();
            chk($sformatf("lb_level_%0d", c), int'(db_out), int'(lvl));
            chk($sformatf("lb_toggles_%0d", c), db_toggles - base, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
